// File: rtl/fx2_slave_fifo_ctrl.sv
// FPGA-side master for the FX2 synchronous slave FIFO: one OUT endpoint to an rx
// stream, one IN endpoint from a tx stream, burst-limited arbitration and PKTEND.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | arbitrate between read and write requests
// RD_SETUP  | OUT endpoint selected, sloe low, bus settles
// RD_STB    | slrd low for one cycle when a word can be taken
// RD_GAP    | strobe gap; flaga and burst decide whether to continue
// RD_END    | sloe high again, bus turnaround
// WR_SETUP  | IN endpoint selected, fd still released
// WR_STB    | fd driven and slwr low while flagd and tx_valid
// WR_GAP    | fd released; packet end, burst end or continue
// PKTEND    | pktend low for one cycle, packet counter cleared
// PKT_GAP   | recovery cycle after pktend
module fx2_slave_fifo_ctrl #(
    parameter int         DATA_W    = 16,
    parameter logic [1:0] OUT_EP    = 2'b00,
    parameter logic [1:0] IN_EP     = 2'b10,
    parameter int         PKT_WORDS = 256,
    parameter int         BURST     = 16,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              usb_flaga,
    input  logic              usb_flagd,
    output logic              usb_slrd,
    output logic              usb_slwr,
    output logic              usb_sloe,
    output logic              usb_pktend,
    output logic [1:0]        usb_fifoaddr,
    inout  wire  [DATA_W-1:0] usb_fd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready
);
    localparam int BW = $clog2(BURST + 1);
    localparam int PW = (PKT_WORDS < 2) ? 1 : $clog2(PKT_WORDS);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_SETUP, S_RD_STB, S_RD_GAP, S_RD_END,
        S_WR_SETUP, S_WR_STB, S_WR_GAP, S_PKTEND, S_PKT_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fifoaddr_q, fifoaddr_d;
    logic              last_dir_q, last_dir_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              wr_last_q, wr_last_d;
    logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              commit_pend_q, commit_pend_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic rd_req, wr_req, rd_fire, wr_fire, rx_full, fd_oe;

    assign rd_req  = usb_flaga & ~rx_valid_q;
    assign wr_req  = (usb_flagd & tx_valid) | commit_pend_q;
    assign rd_fire = (state_q == S_RD_STB) & usb_flaga & (~rx_valid_q | rx_ready);
    assign wr_fire = (state_q == S_WR_STB) & usb_flagd & tx_valid;
    assign rx_full = rx_valid_q & ~rx_ready;

    always_comb begin
        state_d    = state_q;
        fifoaddr_d = fifoaddr_q;
        last_dir_d = last_dir_q;
        burst_d    = burst_q;
        wr_last_d  = wr_last_q;
        case (state_q)
            S_IDLE: begin
                burst_d = '0;
                if (rd_req && (!wr_req || last_dir_q == DIR_WR)) begin
                    state_d    = S_RD_SETUP;
                    fifoaddr_d = OUT_EP;
                    last_dir_d = DIR_RD;
                end else if (wr_req) begin
                    state_d    = S_WR_SETUP;
                    fifoaddr_d = IN_EP;
                    last_dir_d = DIR_WR;
                end
            end
            S_RD_SETUP: state_d = S_RD_STB;
            S_RD_STB: begin
                if (rd_fire) begin
                    burst_d = burst_q + BW'(1);
                    state_d = S_RD_GAP;
                end else begin
                    state_d = S_RD_END;
                end
            end
            S_RD_GAP: begin
                if (burst_q == BW'(BURST) || !usb_flaga || rx_full) state_d = S_RD_END;
                else                                                 state_d = S_RD_STB;
            end
            S_RD_END: state_d = S_IDLE;
            // A timeout commit skips the data phase entirely.
            S_WR_SETUP: begin
                if (commit_pend_q && pkt_cnt_q != '0) state_d = S_PKTEND;
                else                                  state_d = S_WR_STB;
            end
            S_WR_STB: begin
                if (wr_fire) begin
                    burst_d   = burst_q + BW'(1);
                    wr_last_d = tx_last;
                    state_d   = S_WR_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_GAP: begin
                if (wr_last_q && pkt_cnt_q != '0)                                state_d = S_PKTEND;
                else if (burst_q == BW'(BURST) || !usb_flagd || !tx_valid)       state_d = S_IDLE;
                else                                                             state_d = S_WR_STB;
            end
            S_PKTEND:  state_d = S_PKT_GAP;
            S_PKT_GAP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Packet word count, idle timeout and the deferred commit request.
    always_comb begin
        pkt_cnt_d     = pkt_cnt_q;
        to_cnt_d      = to_cnt_q;
        commit_pend_d = commit_pend_q;
        if (wr_fire)
            pkt_cnt_d = (pkt_cnt_q == PW'(PKT_WORDS - 1)) ? '0 : pkt_cnt_q + PW'(1);
        if (state_q == S_PKTEND) begin
            pkt_cnt_d     = '0;
            to_cnt_d      = '0;
            commit_pend_d = 1'b0;
        end else if (wr_fire) begin
            to_cnt_d = '0;
        end else if (pkt_cnt_q == '0) begin
            to_cnt_d      = '0;
            commit_pend_d = 1'b0;
        end else if (TIMEOUT != 0 && to_cnt_q != TW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TW'(TIMEOUT)) commit_pend_d = 1'b1;
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rd_fire) begin
            rx_data_d  = usb_fd;
            rx_valid_d = 1'b1;
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fifoaddr_q    <= OUT_EP;
            last_dir_q    <= DIR_WR;
            burst_q       <= '0;
            wr_last_q     <= 1'b0;
            pkt_cnt_q     <= '0;
            to_cnt_q      <= '0;
            commit_pend_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifoaddr_q    <= fifoaddr_d;
            last_dir_q    <= last_dir_d;
            burst_q       <= burst_d;
            wr_last_q     <= wr_last_d;
            pkt_cnt_q     <= pkt_cnt_d;
            to_cnt_q      <= to_cnt_d;
            commit_pend_q <= commit_pend_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
        end
    end

    // Strobes decode from the state register so reset releases them at once.
    assign usb_slrd     = ~rd_fire;
    assign usb_slwr     = ~wr_fire;
    assign usb_pktend   = ~(state_q == S_PKTEND);
    assign usb_sloe     = ~(state_q inside {S_RD_SETUP, S_RD_STB, S_RD_GAP});
    assign usb_fifoaddr = fifoaddr_q;
    assign fd_oe        = (state_q == S_WR_STB);
    assign usb_fd       = fd_oe ? tx_data : 'z;
    assign tx_ready     = wr_fire;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
endmodule
